// File: rtl/knap_search_if.sv
// Loader / readout bundle for knap_search: item-table writes, sweep limits,
// start handshake and the reported best-subset result.
interface knap_search_if #(
  parameter int N_ITEMS = 5,
  parameter int W       = 16,
  parameter int ACC_W   = 32
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic               load_en;
  logic [IDX_W-1:0]   load_idx;
  logic [W-1:0]       load_weight;
  logic [W-1:0]       load_value;
  logic [ACC_W-1:0]   max_weight;
  logic [ACC_W-1:0]   min_value;
  logic               start;
  logic               busy;
  logic               done;
  logic               best_valid;
  logic [N_ITEMS-1:0] best_mask;
  logic [ACC_W-1:0]   best_value;
  logic [ACC_W-1:0]   best_weight;
  logic [N_ITEMS:0]   feasible_count;

  modport master (
    output load_en, load_idx, load_weight, load_value, max_weight, min_value, start,
    input  busy, done, best_valid, best_mask, best_value, best_weight, feasible_count
  );

  modport slave (
    input  load_en, load_idx, load_weight, load_value, max_weight, min_value, start,
    output busy, done, best_valid, best_mask, best_value, best_weight, feasible_count
  );
endinterface

// File: rtl/knap_search.sv
// Brute-force 0/1 knapsack: sweeps every selection mask at one per clock and
// keeps the highest-value feasible subset plus a count of feasible subsets.
module knap_search #(
  parameter int N_ITEMS = 5,
  parameter int W       = 16,
  parameter int ACC_W   = 32
) (
  input logic clk,
  input logic rst,
  knap_search_if.slave bus
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam logic [N_ITEMS-1:0] CNT_LAST = '1;
  localparam logic [N_ITEMS-1:0] CNT_ONE  = N_ITEMS'(1);
  localparam logic [N_ITEMS:0]   FCNT_ONE = (N_ITEMS+1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  typedef logic [N_ITEMS-1:0][W-1:0] table_t;

  function automatic logic [ACC_W-1:0] sum_selected(input logic [N_ITEMS-1:0] mask,
                                                    input table_t tab);
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (mask[i]) acc = acc + ACC_W'(tab[i]);
    return acc;
  endfunction

  function automatic logic is_feasible(input logic [ACC_W-1:0] wsum, input logic [ACC_W-1:0] vsum,
                                       input logic [ACC_W-1:0] wlim, input logic [ACC_W-1:0] vmin);
    return (vsum >= vmin) && (wsum <= wlim);
  endfunction

  state_t             state_q, state_d;
  table_t             wt_tab_q, wt_tab_d, val_tab_q, val_tab_d;
  table_t             wt_run_q, wt_run_d, val_run_q, val_run_d;
  logic [ACC_W-1:0]   max_w_q, max_w_d, min_v_q, min_v_d;
  logic [N_ITEMS-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]   wsum_p1_q, wsum_p1_d, vsum_p1_q, vsum_p1_d;
  logic [N_ITEMS-1:0] mask_p1_q, mask_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic               best_valid_q, best_valid_d;
  logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
  logic [ACC_W-1:0]   best_value_q, best_value_d, best_weight_q, best_weight_d;
  logic [N_ITEMS:0]   fcnt_q, fcnt_d;

  always_comb begin
    state_d       = state_q;
    wt_tab_d      = wt_tab_q;
    val_tab_d     = val_tab_q;
    wt_run_d      = wt_run_q;
    val_run_d     = val_run_q;
    max_w_d       = max_w_q;
    min_v_d       = min_v_q;
    cnt_d         = cnt_q;
    best_valid_d  = best_valid_q;
    best_mask_d   = best_mask_q;
    best_value_d  = best_value_q;
    best_weight_d = best_weight_q;
    fcnt_d        = fcnt_q;

    // Stage A: sums of the items selected by the current counter value
    wsum_p1_d = sum_selected(cnt_q, wt_run_q);
    vsum_p1_d = sum_selected(cnt_q, val_run_q);
    mask_p1_d = cnt_q;
    vld_p1_d  = (state_q == SCAN);

    // Stage B: feasibility and best-so-far; strict > keeps the lower mask on ties
    if (vld_p1_q && is_feasible(wsum_p1_q, vsum_p1_q, max_w_q, min_v_q)) begin
      fcnt_d = fcnt_q + FCNT_ONE;
      if (!best_valid_q || (vsum_p1_q > best_value_q)) begin
        best_valid_d  = 1'b1;
        best_mask_d   = mask_p1_q;
        best_value_d  = vsum_p1_q;
        best_weight_d = wsum_p1_q;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        for (int i = 0; i < N_ITEMS; i++) begin
          if (bus.load_en && (bus.load_idx == IDX_W'(i))) begin
            wt_tab_d[i]  = bus.load_weight;
            val_tab_d[i] = bus.load_value;
          end
        end
        if (bus.start) begin
          // Snapshot the pre-edge table so a same-cycle write misses this sweep
          wt_run_d      = wt_tab_q;
          val_run_d     = val_tab_q;
          max_w_d       = bus.max_weight;
          min_v_d       = bus.min_value;
          cnt_d         = '0;
          best_valid_d  = 1'b0;
          best_mask_d   = '0;
          best_value_d  = '0;
          best_weight_d = '0;
          fcnt_d        = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wt_tab_q      <= '0;
      val_tab_q     <= '0;
      wt_run_q      <= '0;
      val_run_q     <= '0;
      max_w_q       <= '0;
      min_v_q       <= '0;
      cnt_q         <= '0;
      wsum_p1_q     <= '0;
      vsum_p1_q     <= '0;
      mask_p1_q     <= '0;
      vld_p1_q      <= 1'b0;
      best_valid_q  <= 1'b0;
      best_mask_q   <= '0;
      best_value_q  <= '0;
      best_weight_q <= '0;
      fcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      wt_tab_q      <= wt_tab_d;
      val_tab_q     <= val_tab_d;
      wt_run_q      <= wt_run_d;
      val_run_q     <= val_run_d;
      max_w_q       <= max_w_d;
      min_v_q       <= min_v_d;
      cnt_q         <= cnt_d;
      wsum_p1_q     <= wsum_p1_d;
      vsum_p1_q     <= vsum_p1_d;
      mask_p1_q     <= mask_p1_d;
      vld_p1_q      <= vld_p1_d;
      best_valid_q  <= best_valid_d;
      best_mask_q   <= best_mask_d;
      best_value_q  <= best_value_d;
      best_weight_q <= best_weight_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign bus.busy           = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done           = (state_q == DONE);
  assign bus.best_valid     = best_valid_q;
  assign bus.best_mask      = best_mask_q;
  assign bus.best_value     = best_value_q;
  assign bus.best_weight    = best_weight_q;
  assign bus.feasible_count = fcnt_q;
endmodule

// File: tb/tb_knap_search.sv
// Directed bench for knap_search: hand-computed knapsack results, tie-break,
// disturbance during a sweep and reset mid-sweep.
module tb_knap_search;
  localparam int N   = 5;
  localparam int W   = 16;
  localparam int ACC = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  knap_search_if #(.N_ITEMS(N), .W(W), .ACC_W(ACC)) bus();
  knap_search #(.N_ITEMS(N), .W(W), .ACC_W(ACC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  logic busy_at_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_item(input int idx, input int w, input int v);
    bus.load_en = 1'b1;
    bus.load_idx = 3'(idx);
    bus.load_weight = 16'(w);
    bus.load_value = 16'(v);
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic load_five();
    load_item(0, 12, 4);
    load_item(1, 1, 2);
    load_item(2, 2, 2);
    load_item(3, 1, 1);
    load_item(4, 4, 10);
  endtask

  // dist_at >= 0 pulses start+load_en at that sweep cycle; ld_start writes item 0 with start
  task automatic run_sweep(input int maxw, input int minv, input int dist_at, input bit ld_start);
    bus.max_weight = 32'(maxw);
    bus.min_value = 32'(minv);
    bus.start = 1'b1;
    if (ld_start) begin
      bus.load_en = 1'b1; bus.load_idx = 3'd0; bus.load_weight = 16'd0; bus.load_value = 16'd100;
    end
    tick();
    busy_at_start = bus.busy;
    bus.start = 1'b0;
    bus.load_en = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == dist_at) begin
        bus.start = 1'b1; bus.load_en = 1'b1;
        bus.load_idx = 3'd0; bus.load_weight = 16'd0; bus.load_value = 16'd100;
      end
      tick();
      cyc++;
      bus.start = 1'b0;
      bus.load_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load_en = 0; bus.load_idx = 0; bus.load_weight = 0; bus.load_value = 0;
    bus.max_weight = 0; bus.min_value = 0; bus.start = 0;
    tick(); tick();
    rst = 1'b0;
    n_chk++; if ({bus.busy, bus.done, bus.best_valid} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.done, bus.best_valid}); else n_pass++;
    n_chk++; if (bus.best_mask !== 5'd0) $display("FAIL reset_mask got %0d want 0", bus.best_mask); else n_pass++;
    n_chk++; if ({bus.best_value, bus.best_weight} !== 64'd0) $display("FAIL reset_vw got %0d/%0d want 0/0", bus.best_value, bus.best_weight); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd0) $display("FAIL reset_fcnt got %0d want 0", bus.feasible_count); else n_pass++;
  endtask

  task automatic test_five_item();
    load_five();
    run_sweep(16, 15, -1, 0);
    n_chk++; if (busy_at_start !== 1'b1) $display("FAIL five_busy_start got %b want 1", busy_at_start); else n_pass++;
    n_chk++; if (cyc !== 33) $display("FAIL five_latency got %0d want 33", cyc); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL five_busy_done got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.best_valid !== 1'b1) $display("FAIL five_valid got %b want 1", bus.best_valid); else n_pass++;
    n_chk++; if (bus.best_mask !== 5'b11110) $display("FAIL five_mask got %b want 11110", bus.best_mask); else n_pass++;
    n_chk++; if (bus.best_value !== 32'd15) $display("FAIL five_value got %0d want 15", bus.best_value); else n_pass++;
    n_chk++; if (bus.best_weight !== 32'd8) $display("FAIL five_weight got %0d want 8", bus.best_weight); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd1) $display("FAIL five_fcnt got %0d want 1", bus.feasible_count); else n_pass++;
    // a write while done must not disturb the reported result
    load_item(0, 99, 99);
    n_chk++; if (bus.done !== 1'b1) $display("FAIL done_write_done got %b want 1", bus.done); else n_pass++;
    n_chk++; if ({bus.best_mask, bus.best_value} !== {5'b11110, 32'd15}) $display("FAIL done_write_result got %b/%0d want 11110/15", bus.best_mask, bus.best_value); else n_pass++;
    load_item(0, 12, 4);
  endtask

  task automatic test_infeasible();
    run_sweep(16, 20, -1, 0);
    n_chk++; if (bus.best_valid !== 1'b0) $display("FAIL none_valid got %b want 0", bus.best_valid); else n_pass++;
    n_chk++; if (bus.best_mask !== 5'd0) $display("FAIL none_mask got %b want 00000", bus.best_mask); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd0) $display("FAIL none_fcnt got %0d want 0", bus.feasible_count); else n_pass++;
  endtask

  task automatic test_empty_only();
    run_sweep(0, 0, -1, 0);
    n_chk++; if (bus.best_valid !== 1'b1) $display("FAIL empty_valid got %b want 1", bus.best_valid); else n_pass++;
    n_chk++; if (bus.best_mask !== 5'd0) $display("FAIL empty_mask got %b want 00000", bus.best_mask); else n_pass++;
    n_chk++; if ({bus.best_value, bus.best_weight} !== 64'd0) $display("FAIL empty_vw got %0d/%0d want 0/0", bus.best_value, bus.best_weight); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd1) $display("FAIL empty_fcnt got %0d want 1", bus.feasible_count); else n_pass++;
  endtask

  task automatic test_tie_break();
    load_item(0, 3, 7);
    load_item(1, 3, 7);
    load_item(2, 50, 0);
    load_item(3, 50, 0);
    load_item(4, 50, 0);
    run_sweep(5, 1, -1, 0);
    n_chk++; if (bus.best_mask !== 5'b00001) $display("FAIL tie_mask got %b want 00001", bus.best_mask); else n_pass++;
    n_chk++; if ({bus.best_value, bus.best_weight} !== {32'd7, 32'd3}) $display("FAIL tie_vw got %0d/%0d want 7/3", bus.best_value, bus.best_weight); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd2) $display("FAIL tie_fcnt got %0d want 2", bus.feasible_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    load_five();
    run_sweep(16, 15, 5, 0);
    n_chk++; if (cyc !== 33) $display("FAIL dist_latency got %0d want 33", cyc); else n_pass++;
    n_chk++; if ({bus.best_mask, bus.best_value, bus.feasible_count} !== {5'b11110, 32'd15, 6'd1}) $display("FAIL dist_result got %b/%0d/%0d want 11110/15/1", bus.best_mask, bus.best_value, bus.feasible_count); else n_pass++;
    run_sweep(16, 15, -1, 0);
    n_chk++; if ({bus.best_mask, bus.best_value, bus.best_weight, bus.feasible_count} !== {5'b11110, 32'd15, 32'd8, 6'd1}) $display("FAIL rerun_result got %b/%0d/%0d/%0d want 11110/15/8/1", bus.best_mask, bus.best_value, bus.best_weight, bus.feasible_count); else n_pass++;
    // same-edge write commits but is invisible to the sweep it starts with
    run_sweep(16, 15, -1, 1);
    n_chk++; if ({bus.best_mask, bus.best_value, bus.feasible_count} !== {5'b11110, 32'd15, 6'd1}) $display("FAIL ldstart_result got %b/%0d/%0d want 11110/15/1", bus.best_mask, bus.best_value, bus.feasible_count); else n_pass++;
    run_sweep(16, 15, -1, 0);
    n_chk++; if ({bus.best_mask, bus.best_value, bus.best_weight} !== {5'b11111, 32'd115, 32'd8}) $display("FAIL ldnext_best got %b/%0d/%0d want 11111/115/8", bus.best_mask, bus.best_value, bus.best_weight); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd17) $display("FAIL ldnext_fcnt got %0d want 17", bus.feasible_count); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    load_five();
    bus.max_weight = 32'd16; bus.min_value = 32'd15; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({bus.busy, bus.done, bus.best_valid} !== 3'b000) $display("FAIL midrst_ctrl got %b want 000", {bus.busy, bus.done, bus.best_valid}); else n_pass++;
    n_chk++; if ({bus.best_mask, bus.best_value, bus.best_weight, bus.feasible_count} !== 75'd0) $display("FAIL midrst_result got %b/%0d/%0d/%0d want 0/0/0/0", bus.best_mask, bus.best_value, bus.best_weight, bus.feasible_count); else n_pass++;
    run_sweep(16, 0, -1, 0);
    n_chk++; if (bus.done !== 1'b1) $display("FAIL zero_tab_done got %b want 1", bus.done); else n_pass++;
    n_chk++; if (bus.feasible_count !== 6'd32) $display("FAIL zero_tab_fcnt got %0d want 32", bus.feasible_count); else n_pass++;
    n_chk++; if ({bus.best_valid, bus.best_mask, bus.best_value} !== {1'b1, 5'd0, 32'd0}) $display("FAIL zero_tab_best got %b/%b/%0d want 1/00000/0", bus.best_valid, bus.best_mask, bus.best_value); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_five_item();
    test_infeasible();
    test_empty_only();
    test_tie_break();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
